// File: rtl/div_8by4_seq.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor,
// one quotient bit per cycle through a shared 5-bit subtractor.
module div_8by4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0] dq;
    logic [4:0] pr;
    logic [3:0] dsr;
    logic [2:0] cnt;
    logic       dz;

    logic [4:0] pr_sh;
    logic [4:0] diff;
    logic       ge;
    logic [4:0] pr_nxt;
    logic [7:0] dq_nxt;
    logic       unused_pr_msb;

    assign pr_sh  = {pr[3:0], dq[7]};
    assign diff   = pr_sh - {1'b0, dsr};
    assign ge     = (pr_sh >= {1'b0, dsr});
    assign pr_nxt = ge ? diff : pr_sh;
    assign dq_nxt = {dq[6:0], ge};
    // pr[4] is always zero once an iteration has restored
    assign unused_pr_msb = pr[4];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (cnt == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dq        <= '0;
            pr        <= '0;
            dsr       <= '0;
            cnt       <= '0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            dq  <= dividend;
            dsr <= divisor;
            pr  <= '0;
            cnt <= '0;
            dz  <= (divisor == 4'd0);
        end else if (state == CALC) begin
            dq  <= dq_nxt;
            pr  <= pr_nxt;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                // zero divisor still runs all 8 steps, then saturates
                quotient  <= dz ? 8'hFF : dq_nxt;
                remainder <= dz ? 4'hF : pr_nxt[3:0];
                div_zero  <= dz;
            end
        end
    end

endmodule

// File: tb/tb_div_8by4_seq.sv
// Directed and exhaustive self-checking bench for div_8by4_seq.
module tb_div_8by4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_8by4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one operation and wait for out_valid; outputs left pending.
    task automatic start_op(input logic [7:0] a, input logic [3:0] d,
                            output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 30) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic dir_op(input string tag, input logic [7:0] a,
                          input logic [3:0] d, input logic [7:0] eq,
                          input logic [3:0] er, input logic ez);
        int lat;
        start_op(a, d, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd8);
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dz"}, 32'(div_zero), 32'(ez));
        finish_op();
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);

        dir_op("d15_4", 8'd15, 4'd4, 8'd3, 4'd3, 1'b0);
        dir_op("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        dir_op("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        dir_op("d3_5", 8'd3, 4'd5, 8'd0, 4'd3, 1'b0);
        dir_op("d0_9", 8'd0, 4'd9, 8'd0, 4'd0, 1'b0);
        dir_op("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0);

        start_op(8'd144, 4'd12, lat);
        chk("bp_lat", 32'(lat), 32'd8);
        dividend = 8'd9;
        divisor  = 4'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_q", 32'(quotient), 32'd12);
            chk("bp_r", 32'(remainder), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        finish_op();
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        chk("bp_hold_q", 32'(quotient), 32'd12);

        dir_op("d77_0", 8'd77, 4'd0, 8'hFF, 4'hF, 1'b1);
        dir_op("d77_7", 8'd77, 4'd7, 8'd11, 4'd0, 1'b0);

        dividend = 8'd100;
        divisor  = 4'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_q", 32'(quotient), 32'd0);
        chk("mid_rst_r", 32'(remainder), 32'd0);
        chk("mid_rst_dz", 32'(div_zero), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
        dir_op("d100_3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0);

        for (int a = 0; a < 256; a++) begin
            for (int d = 1; d < 16; d++) begin
                start_op(8'(a), 4'(d), lat);
                chk("ex_lat", 32'(lat), 32'd8);
                chk("ex_identity", 32'(quotient) * 32'(d) + 32'(remainder),
                    32'(a));
                chk("ex_r_lt_d", 32'(32'(remainder) < 32'(d)), 32'd1);
                chk("ex_q", 32'(quotient), 32'(a / d));
                chk("ex_dz", 32'(div_zero), 32'd0);
                finish_op();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
